// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one clocked 16-bit ALU between two requesters. Requester 0 is the
// main execute path and requester 1 is the address/branch-compare path.
// Each operation moves through IDLE -> EXEC -> CAPT. In IDLE the arbiter
// picks a winner and latches its operation into the alu_* registers. EXEC
// gives the ALU its one clock of latency. CAPT captures the ALU outputs and
// pulses the owner's rvalid in the following cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   reqN, aluopN, input1_N, immdN, reg_outN, alusrcN
//                       request and operation from requester N (N = 0/1)
//   gntN                request accepted this cycle (combinational, IDLE only)
//   rvalidN             one-cycle result-valid pulse to requester N
//   result, result_zero captured ALU result and zero flag, shared by both
//   busy                high while an operation is in EXEC or CAPT
//   alu_*               registered operation driven into the ALU
//   alu_out, alu_zero   ALU outputs
//
// Configuration macro: ALU_ARB_FIXED_PRI_EN
//   When defined, requester 0 always wins ties and the round-robin pointer
//   does not exist. When undefined, ties alternate (round-robin).
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   aluop0,
  input  logic [OPW-1:0]   aluop1,
  input  logic [WIDTH-1:0] input1_0,
  input  logic [WIDTH-1:0] input1_1,
  input  logic [WIDTH-1:0] immd0,
  input  logic [WIDTH-1:0] immd1,
  input  logic [WIDTH-1:0] reg_out0,
  input  logic [WIDTH-1:0] reg_out1,
  input  logic             alusrc0,
  input  logic             alusrc1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             busy,
  output logic [OPW-1:0]   alu_aluop,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_immd,
  output logic [WIDTH-1:0] alu_reg_out,
  output logic             alu_alusrc,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   alu_aluop_q, alu_aluop_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d;
  logic [WIDTH-1:0] alu_immd_q, alu_immd_d;
  logic [WIDTH-1:0] alu_reg_out_q, alu_reg_out_d;
  logic             alu_alusrc_q, alu_alusrc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_zero_q, result_zero_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             any_req;
  logic             pick1;
`ifndef ALU_ARB_FIXED_PRI_EN
  // 1 means requester 1 was served most recently.
  logic             last_q, last_d;
`endif

  // Winner selection. pick1 is only meaningful when some request is present.
  always_comb begin
    any_req = req0 | req1;
`ifdef ALU_ARB_FIXED_PRI_EN
    pick1 = req1 & ~req0;
`else
    pick1 = req1 & (~req0 | ~last_q);
`endif
  end

  // Grants are masked by rst so a reset cycle never accepts a request.
  assign gnt0 = (state_q == IDLE) & ~rst & any_req & ~pick1;
  assign gnt1 = (state_q == IDLE) & ~rst & pick1;

  // Next-state, operation latch and result capture.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    alu_aluop_d   = alu_aluop_q;
    alu_input1_d  = alu_input1_q;
    alu_immd_d    = alu_immd_q;
    alu_reg_out_d = alu_reg_out_q;
    alu_alusrc_d  = alu_alusrc_q;
    result_d      = result_q;
    result_zero_d = result_zero_q;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = EXEC;
          owner_d       = pick1;
          alu_aluop_d   = pick1 ? aluop1   : aluop0;
          alu_input1_d  = pick1 ? input1_1 : input1_0;
          alu_immd_d    = pick1 ? immd1    : immd0;
          alu_reg_out_d = pick1 ? reg_out1 : reg_out0;
          alu_alusrc_d  = pick1 ? alusrc1  : alusrc0;
`ifndef ALU_ARB_FIXED_PRI_EN
          last_d        = pick1;
`endif
        end
      end
      EXEC: begin
        state_d = CAPT;
      end
      CAPT: begin
        state_d       = IDLE;
        result_d      = alu_out;
        result_zero_d = alu_zero;
        rvalid0_d     = ~owner_q;
        rvalid1_d     = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      alu_aluop_q   <= '0;
      alu_input1_q  <= '0;
      alu_immd_q    <= '0;
      alu_reg_out_q <= '0;
      alu_alusrc_q  <= 1'b0;
      result_q      <= '0;
      result_zero_q <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      alu_aluop_q   <= alu_aluop_d;
      alu_input1_q  <= alu_input1_d;
      alu_immd_q    <= alu_immd_d;
      alu_reg_out_q <= alu_reg_out_d;
      alu_alusrc_q  <= alu_alusrc_d;
      result_q      <= result_d;
      result_zero_q <= result_zero_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q        <= last_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign result      = result_q;
  assign result_zero = result_zero_q;
  assign alu_aluop   = alu_aluop_q;
  assign alu_input1  = alu_input1_q;
  assign alu_immd    = alu_immd_q;
  assign alu_reg_out = alu_reg_out_q;
  assign alu_alusrc  = alu_alusrc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives two requesters into alu_arbiter, models the external clocked ALU,
// and checks grants, ALU drive, results and timing against a reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v [2];
  logic [2:0]  op_v  [2];
  logic [15:0] a_v   [2];
  logic [15:0] imm_v [2];
  logic [15:0] reg_v [2];
  logic        src_v [2];

  logic        gnt0, gnt1, rvalid0, rvalid1, result_zero, busy;
  logic [15:0] result;
  logic [2:0]  alu_aluop;
  logic [15:0] alu_input1, alu_immd, alu_reg_out;
  logic        alu_alusrc;
  logic [15:0] alu_out = '0;
  logic        alu_zero = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          owner;
    logic [15:0] res;
    logic        z;
    int          due;
  } exp_t;
  exp_t sbq[$];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .aluop0(op_v[0]), .aluop1(op_v[1]),
    .input1_0(a_v[0]), .input1_1(a_v[1]),
    .immd0(imm_v[0]), .immd1(imm_v[1]),
    .reg_out0(reg_v[0]), .reg_out1(reg_v[1]),
    .alusrc0(src_v[0]), .alusrc1(src_v[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .result(result), .result_zero(result_zero), .busy(busy),
    .alu_aluop(alu_aluop), .alu_input1(alu_input1), .alu_immd(alu_immd),
    .alu_reg_out(alu_reg_out), .alu_alusrc(alu_alusrc),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic the environment ALU performs; b is already the selected operand.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[3:0];
      3'd6: return a >> b[3:0];
      default: return (a < b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  // Environment ALU with one clock of latency.
  always @(posedge clk) begin
    alu_out  <= alu_fn(alu_aluop, alu_input1, alu_alusrc ? alu_immd : alu_reg_out);
    alu_zero <= (alu_fn(alu_aluop, alu_input1, alu_alusrc ? alu_immd : alu_reg_out) == 16'd0);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter: free_at is the first cycle the arbiter can grant again,
  // last_srv is who was served most recently.
  int          free_at = 0;
  int          last_srv = 1;
  bit          alu_pend = 0;
  logic [2:0]  e_op;
  logic [15:0] e_a, e_imm, e_reg;
  logic        e_src;

  always @(negedge clk) begin
    int w;
    logic [15:0] r;
    #1;
    if (alu_pend) begin
      checkOutput("alu_aluop", alu_aluop, e_op);
      checkOutput("alu_input1", alu_input1, e_a);
      checkOutput("alu_immd", alu_immd, e_imm);
      checkOutput("alu_reg_out", alu_reg_out, e_reg);
      checkOutput("alu_alusrc", alu_alusrc, e_src);
      alu_pend = 0;
    end
    if (rst) begin
      sbq.delete();
      free_at = cyc + 1;
      last_srv = 1;
    end else begin
      checkOutput("busy", busy, (cyc < free_at) ? 1 : 0);
      w = -1;
      if (cyc >= free_at && (req_v[0] || req_v[1])) begin
`ifdef ALU_ARB_FIXED_PRI_EN
        w = req_v[0] ? 0 : 1;
`else
        if (req_v[0] && req_v[1]) w = (last_srv == 0) ? 1 : 0;
        else w = req_v[0] ? 0 : 1;
`endif
      end
      checkOutput("gnt0", gnt0, (w == 0) ? 1 : 0);
      checkOutput("gnt1", gnt1, (w == 1) ? 1 : 0);
      if (w >= 0) begin
        r = alu_fn(op_v[w], a_v[w], src_v[w] ? imm_v[w] : reg_v[w]);
        sbq.push_back('{owner: w, res: r, z: (r == 16'd0), due: cyc + 3});
        free_at = cyc + 3;
        last_srv = w;
        alu_pend = 1;
        e_op = op_v[w]; e_a = a_v[w]; e_imm = imm_v[w]; e_reg = reg_v[w]; e_src = src_v[w];
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result is presented and checks
  // that the shared result holds between captures.
  logic [15:0] held_res = '0;
  logic        held_z = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rvalid0 || rvalid1) begin
      checkOutput("rvalid_onehot", (rvalid0 && rvalid1) ? 1 : 0, 0);
      if (sbq.size() == 0) begin
        checkOutput("rvalid_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("rvalid_owner", rvalid1 ? 1 : 0, e.owner);
        checkOutput("rvalid_cycle", cyc, e.due);
        checkOutput("result", result, e.res);
        checkOutput("result_zero", result_zero, e.z);
        held_res = e.res;
        held_z = e.z;
      end
    end else begin
      checkOutput("result_hold", result, held_res);
      checkOutput("zero_hold", result_zero, held_z);
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        checkOutput("rvalid_missing", 0, 1);
      end
    end
    if (rst) begin
      held_res = '0;
      held_z = 1'b0;
    end
  end

  task automatic newOp(input int i);
    op_v[i]  = 3'($urandom_range(0, 7));
    a_v[i]   = 16'($urandom);
    imm_v[i] = 16'($urandom);
    reg_v[i] = ($urandom_range(0, 3) == 0) ? a_v[i] : 16'($urandom);
    src_v[i] = 1'($urandom_range(0, 1));
  endtask

  // One cycle of requester behaviour: hold until granted, then drop or reissue.
  bit gseen [2];
  int gc [2];

  task automatic applyStimulus(input bit force_both);
    @(negedge clk);
    gseen[0] = gnt0;
    gseen[1] = gnt1;
    if (gnt0) gc[0]++;
    if (gnt1) gc[1]++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!req_v[i] || gseen[i]) begin
        if (force_both || $urandom_range(0, 2) != 0) begin
          req_v[i] = 1'b1;
          newOp(i);
        end else begin
          req_v[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issueOp(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] imm, input logic [15:0] rg, input logic src);
    bit got;
    @(posedge clk);
    #1;
    req_v[i] = 1'b1; op_v[i] = op; a_v[i] = a; imm_v[i] = imm; reg_v[i] = rg; src_v[i] = src;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (i == 0) ? gnt0 : gnt1;
    end
    if (!got) checkOutput("issue_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_v[i] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rvalid0"}, rvalid0, 0);
    checkOutput({tag, "_rvalid1"}, rvalid1, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_zero"}, result_zero, 0);
    checkOutput({tag, "_alu_aluop"}, alu_aluop, 0);
    checkOutput({tag, "_alu_input1"}, alu_input1, 0);
    checkOutput({tag, "_alu_immd"}, alu_immd, 0);
    checkOutput({tag, "_alu_reg_out"}, alu_reg_out, 0);
    checkOutput({tag, "_alu_alusrc"}, alu_alusrc, 0);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int diff;
    bit got;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; op_v[i] = '0; a_v[i] = '0; imm_v[i] = '0; reg_v[i] = '0; src_v[i] = 1'b0;
      gc[i] = 0;
    end

    // Reset for two cycles, then stay idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    checkOutput("reset_gnt0", gnt0, 0);
    checkOutput("reset_gnt1", gnt1, 0);

    // Directed operations: immediate source, zero-flag cases.
    issueOp(0, 3'd4, 16'd10, 16'd5, 16'd6, 1'b1);
    issueOp(1, 3'd6, 16'd5, 16'd4, 16'd3, 1'b0);
    issueOp(0, 3'd1, 16'd7, 16'd9, 16'd7, 1'b0);
    issueOp(1, 3'd0, 16'hFFFF, 16'd1, 16'd2, 1'b1);

    // Both requesters held high continuously.
    gc[0] = 0;
    gc[1] = 0;
    repeat (36) applyStimulus(1'b1);
    drain();
    diff = gc[0] - gc[1];
`ifdef ALU_ARB_FIXED_PRI_EN
    checkOutput("fixed_gnt1_count", gc[1], 0);
    checkOutput("fixed_gnt0_seen", (gc[0] > 0) ? 1 : 0, 1);
`else
    checkOutput("rr_balance", (diff >= -1 && diff <= 1) ? 1 : 0, 1);
    checkOutput("rr_gnt1_seen", (gc[1] > 0) ? 1 : 0, 1);
`endif

    // Random traffic.
    repeat (400) applyStimulus(1'b0);
    drain();

    // Reset while in EXEC with req1 held: in-flight op dropped, req1 regranted.
    @(posedge clk);
    #1;
    req_v[1] = 1'b1; op_v[1] = 3'd0; a_v[1] = 16'd100; imm_v[1] = 16'd23; reg_v[1] = 16'd1;
    src_v[1] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = gnt1;
    end
    if (!got) checkOutput("midrst_issue_timeout", 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues("midrst");
    checkOutput("midrst_regrant", gnt1, 1);
    drain();

    // Wait for any outstanding results, bounded.
    for (int k = 0; k < 50 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) checkOutput("drain_pending", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit clocked `Alu` between two requesters: requester 0 is the main execute path and requester 1 is the address/branch-compare path. It arbitrates each cycle it is idle, latches the winner's operation into registers that drive the ALU, waits out the ALU's one-clock result latency, and returns `out`/`zero` to the owner with a one-cycle valid pulse. It sits between the control/datapath requesters and the `Alu` instance, which owns no arbitration of its own.

## Interface
- `WIDTH`, 16, datapath width of operands and result
- `OPW`, 3, width of the ALU opcode
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  operation request from requester 0 / 1
- `aluop0`, `aluop1`  in  OPW  opcode per requester
- `input1_0`, `input1_1`  in  WIDTH  first operand
- `immd0`, `immd1`  in  WIDTH  immediate operand
- `reg_out0`, `reg_out1`  in  WIDTH  register operand
- `alusrc0`, `alusrc1`  in  1  operand select (1 = immediate)
- `gnt0`, `gnt1`  out  1  request accepted this cycle (combinational, IDLE only)
- `rvalid0`, `rvalid1`  out  1  result valid for requester 0 / 1, one-cycle pulse
- `result`  out  WIDTH  captured ALU result, shared by both requesters
- `result_zero`  out  1  captured ALU zero flag
- `busy`  out  1  high in EXEC and CAPT
- `alu_aluop`, `alu_input1`, `alu_immd`, `alu_reg_out`, `alu_alusrc`  out  OPW/WIDTH/WIDTH/WIDTH/1  registered drive to the ALU
- `alu_out`  in  WIDTH, `alu_zero`  in  1  ALU outputs

## Operation
- FSM states: IDLE, EXEC, CAPT.
- IDLE: if no request, stay IDLE. If any request, assert the winner's `gnt` combinationally. At the clock edge, latch the winner's aluop/input1/immd/reg_out/alusrc into the `alu_*` registers, record the owner, and go to EXEC.
- EXEC: `alu_*` are held stable while the ALU samples them at the end of this cycle. Go to CAPT unconditionally.
- CAPT: at the clock edge, `result <= alu_out`, `result_zero <= alu_zero`, and the owner's `rvalid` goes high for the next cycle. Go to IDLE.
- Arbitration is round-robin:
  - single request: that requester wins.
  - both requesting: the requester not served last wins.
  - `last` pointer is updated on every grant; reset value is 1, so requester 0 wins the first tie.
- Requesters hold `req` and operands stable until they see `gnt`. A requester may drop `req` in the cycle after its `gnt`. If it keeps `req` high after `gnt`, that is a new request.
- `gnt0` and `gnt1` are never high together. `gnt` is never high outside IDLE.
- Operands and opcode pass through unmodified; undefined opcodes are the ALU's concern.
- `result`/`result_zero` hold their value until the next CAPT.

## Timing
- `gnt` in cycle N → `alu_*` valid in N+1 → ALU result in N+2 → `rvalid`/`result` in N+3.
- IDLE is re-entered in N+3, so a new `gnt` may coincide with the previous `rvalid`. Maximum throughput is one operation per 3 cycles.
- Reset values:
  - state IDLE, `last` = 1
  - `gnt*` = 0, `rvalid*` = 0, `busy` = 0
  - `result` = 0, `result_zero` = 0
  - all `alu_*` = 0
- Reset mid-operation, in EXEC or CAPT: the in-flight operation is discarded and no `rvalid` is issued. A pending request is re-arbitrated from IDLE in the first cycle after `rst` falls.
- `rst` takes priority over every other event in the same cycle.

## Configuration
- `ALU_ARB_FIXED_PRI_EN` defined: requester 0 always wins ties. The `last` pointer is not implemented. Requester 1 can starve, which is accepted for the execute path.
- Macro undefined (default): round-robin as specified under Operation.

## Test plan
- Reset then idle: `rst` high for 2 cycles, no requests → all outputs 0, `busy` 0, state IDLE.
- Single op: `req0`, aluop 4, input1 10, immd 5, reg_out 6, alusrc 1 → `gnt0` in cycle N, `alu_*` = (4,10,5,6,1) in N+1, `rvalid0` in N+3 with `result` equal to the ALU reference model.
- Contention, round-robin: `req0` and `req1` held high continuously → grant order 0,1,0,1 with grants 3 cycles apart. Each `rvalid` goes only to its owner, and `gnt0`/`gnt1` are never high together.
- Zero flag: `req1`, aluop 6, input1 5, immd 4, reg_out 3, alusrc 0 → `rvalid1` at N+3 with `result_zero` matching the model. A subsequent op leaves the previous result held until its own CAPT.
- Reset mid-op: `rst` asserted in EXEC → no `rvalid`, outputs at reset values. A held `req1` is granted in the first cycle after `rst` falls.
- Build with `ALU_ARB_FIXED_PRI_EN`, both requests held → `gnt0` on every grant, `gnt1` never.
